// File: rtl/opcode_pkg.sv
// Opcode type, FSM states and immediate field positions,
// shared by the instruction packer and the immediate extender.
package opcode_pkg;

  typedef enum logic [2:0] {
    R_TYPE = 3'd0,
    I_TYPE = 3'd1,
    U_TYPE = 3'd2,
    S_TYPE = 3'd3,
    B_TYPE = 3'd4,
    J_TYPE = 3'd5
  } opc_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } pack_state_t;

  localparam int I_IMM_HI  = 27;
  localparam int I_IMM_LO  = 15;
  localparam int U_IMM_HI  = 27;
  localparam int U_IMM_LO  = 15;
  localparam int U_IMM2_HI = 9;
  localparam int U_IMM2_LO = 5;

endpackage

// File: rtl/instr_imm_ins.sv
// Combinational immediate inserter: places imm into the
// instruction word so the immediate extender recovers it.
module instr_imm_ins
  import opcode_pkg::*;
(
  input  logic [2:0]  opc,
  input  logic [31:0] fields,
  input  logic [17:0] imm,
  output logic [31:0] word,
  output logic        range_ok
);

  always_comb begin
    word = fields;
    word[31:29] = opc;
    unique case (1'b1)
      (opc == I_TYPE): begin
        word[I_IMM_HI] = imm[17];
        word[I_IMM_HI-1:I_IMM_LO] = imm[11:0];
      end
      (opc == U_TYPE): begin
        word[U_IMM_HI:U_IMM_LO] = imm[17:5];
        word[U_IMM2_HI:U_IMM2_LO] = imm[4:0];
      end
      default: ;
    endcase
  end

  // I-type carries a sign bit plus 12 bits; [16:12] must echo the sign
  assign range_ok = (imm[17:12] == {6{imm[17]}});

endmodule

// File: rtl/instr_pack.sv
// Streaming instruction packer into instruction memory.
// Optional I-type range check: define IMM_RANGE_CHK_EN.
module instr_pack
  import opcode_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_opc,
  input  logic [31:0]       in_fields,
  input  logic [17:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_range
);

  pack_state_t state, state_nx;

  logic              slot_full;
  logic [31:0]       slot_word;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   count;
  logic [31:0]       word;
  logic              range_ok;
  logic              accept;
  logic              wr;
  logic              go;

  instr_imm_ins u_ins (
    .opc      (in_opc),
    .fields   (in_fields),
    .imm      (in_imm),
    .word     (word),
    .range_ok (range_ok)
  );

  assign wr       = slot_full && imem_ready;
  assign in_ready = (state == S_RUN) && (!slot_full || imem_ready);
  assign accept   = in_valid && in_ready;
  assign go       = (state == S_IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (accept && in_last) state_nx = S_DRAIN;
      end
      S_DRAIN: if (wr) state_nx = S_DONE;
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // A write and a new acceptance in one cycle refill the slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_full <= 1'b0;
      slot_word <= '0;
      addr      <= '0;
      count     <= '0;
    end else begin
      if (go) begin
        addr  <= start_addr;
        count <= '0;
      end else if (wr) begin
        addr <= addr + ADDR_W'(1);
        if (count != '1) count <= count + (ADDR_W+1)'(1);
      end
      if (accept) begin
        slot_word <= word;
        slot_full <= 1'b1;
      end else if (wr) begin
        slot_full <= 1'b0;
      end
    end
  end

  assign imem_we    = slot_full;
  assign imem_addr  = addr;
  assign imem_wdata = slot_word;
  assign word_count = count;

`ifdef IMM_RANGE_CHK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (go)
      err_q <= 1'b0;
    else if (accept && in_opc == I_TYPE && !range_ok)
      err_q <= 1'b1;
  end

  assign err_range = err_q;
`else
  logic unused_range_ok;
  assign unused_range_ok = range_ok;
  assign err_range = 1'b0;
`endif

endmodule

// File: doc/instr_pack.md
# instr_pack

Streaming instruction packer that turns decoded instruction tuples (opcode, non-immediate fields, 18-bit immediate) back into 32-bit instruction words. It writes them sequentially into instruction memory from a programmed base address. It is the encode side of the immediate extender: it places the immediate bits so that the extender recovers the original value. It sits between the host program loader and the instruction memory write port.

## Interface

Parameters:
- ADDR_W, default 10: instruction memory word-address width.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load session; ignored unless IDLE.
- start_addr  input  ADDR_W  first word address, captured on start.
- in_valid  input  1  tuple valid.
- in_ready  output  1  tuple accepted when in_valid && in_ready.
- in_opc  input  3  opcode (opc_t), becomes instr[31:29].
- in_fields  input  32  non-immediate bits; immediate positions and [31:29] are ignored.
- in_imm  input  18  immediate to encode.
- in_last  input  1  final tuple of the session.
- imem_we  output  1  write request.
- imem_ready  input  1  memory accepts the write this cycle.
- imem_addr  output  ADDR_W  word address.
- imem_wdata  output  32  packed word.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse after the last word is written.
- word_count  output  ADDR_W+1  words written this session; saturates at all-ones.
- err_range  output  1  sticky I-type range error.

## Operation

- Packing:
  - Bits [31:29] = in_opc.
  - I_TYPE: instr[27] = imm[17]; instr[26:15] = imm[11:0].
  - U_TYPE: instr[27:15] = imm[17:5]; instr[9:5] = imm[4:0].
  - Any other opcode: in_fields is passed unchanged apart from [31:29].
  - All non-immediate bits come from in_fields.
- I_TYPE range rule: a value is representable iff imm[17:12] are all equal to imm[17]. Otherwise the word is still written, truncated per the packing rule.
- FSM states:
  - IDLE: start → RUN. Capture start_addr. Clear word_count and err_range.
  - RUN: accept tuples. The accepted tuple with in_last moves the FSM to DRAIN and drops in_ready.
  - DRAIN: when the pending word is written → DONE.
  - DONE: one cycle, done=1 → IDLE.
- Output stage is a single register slot.
  - in_ready = (state==RUN) && (!imem_we || imem_ready).
  - imem_we is high whenever the slot is full.
  - A write completes on imem_we && imem_ready. Then the address increments and word_count increments, saturating.
- Address wrap: imem_addr wraps modulo 2^ADDR_W with no flag.
- Simultaneous events:
  - A slot write and a new acceptance in the same cycle refill the slot with no bubble.
  - start during RUN, DRAIN or DONE is ignored.
- Reset mid-session returns to IDLE. The pending word is discarded and imem_we drops immediately.

## Timing

- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, word_count=0, err_range=0.
- Session start: start in cycle N gives busy=1 and in_ready able to assert in cycle N+1.
- Write latency: a tuple accepted in cycle N is presented (imem_we=1) in cycle N+1, then held stable until imem_ready.
- Throughput: one word per cycle with imem_ready held high.
- Session end: if the last write completes in cycle M, done=1 in cycle M+1 and the FSM is in IDLE in cycle M+2.
- err_range sets in the cycle after the offending acceptance.

## Configuration

- IMM_RANGE_CHK_EN defined: the I-type range check is active and err_range is sticky until the next start or reset.
- IMM_RANGE_CHK_EN undefined: no check logic is built; err_range is tied to 0. Packing is identical.

## Structure

- opcode_pkg: holds opc_t (I_TYPE, U_TYPE). Add immediate field-position localparams there, shared with the extender: I_IMM_HI=27, I_IMM_LO=15, U_IMM_HI=27, U_IMM_LO=15, U_IMM2_HI=9, U_IMM2_LO=5.
- Sub-module instr_imm_ins: purely combinational (opc, fields, imm) → (word, range_ok). It instantiates cleanly beside imm_ext for round-trip checking.
- instr_pack contains the FSM, output slot, address counter, word counter and error flag.

## Test plan

- Session at start_addr=0x010 with one U_TYPE tuple, imm=18'h2ABCD, in_fields=0, in_last=1 → one write at 0x010 with instr[27:15]=13'h155E and instr[9:5]=5'h0D. done pulses once and word_count=1.
- Session with I_TYPE imm=18'h3FFFF then imm=18'h01000 (last) → writes at consecutive addresses. The second word has instr[27]=0 and instr[26:15]=0. err_range=1 when IMM_RANGE_CHK_EN is defined, 0 otherwise.
- Four tuples with imem_ready toggling 1,0,0,1,… → no word is lost or duplicated, and imem_wdata and imem_addr stay stable while stalled.
- start_addr=2^ADDR_W-2 with 3 tuples → addresses run max-1, max, 0.
- rst_n asserted while imem_we=1 → imem_we=0 and busy=0 immediately, word_count=0, and the FSM is in IDLE after release.
- Round trip: 256 random I_TYPE and U_TYPE tuples, each in-range → imm_ext(imem_wdata) equals in_imm for every word.
